countdown_timer: RTL and testbench

- Loadable down-counter that counts toward zero and raises a one-cycle expiry pulse. It is the down-counting companion to the team's up-counter/compare block.
- Software or an upstream FSM programs a reload value, then starts and stops the timer. A tick input, divided by a fixed prescaler, drives the decrements.
- Supports one-shot and auto-reload (periodic) modes.

---
 rtl/countdown_timer.sv | 95 +++++++++
 tb/tb_countdown_timer.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/countdown_timer.sv
// countdown_timer: loadable down-counter with a tick prescaler, one-shot and
// auto-reload modes, and a one-cycle expiry pulse.
//
// Request semantics: load, start and stop are single-cycle requests sampled
// on the rising edge of clk. There is no back-pressure, so each request takes
// effect at the edge that samples it. Requests are resolved in the priority
// order rst > stop > load > start > tick. The FSM state is visible on busy,
// which is high exactly while the timer is in RUN.
module countdown_timer #(
    parameter int WIDTH    = 8,
    parameter int PRESCALE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             start,
    input  logic             stop,
    input  logic             tick,
    input  logic             auto_reload,
    output logic [WIDTH-1:0] cnt,
    output logic             busy,
    output logic             zero,
    output logic             expired
);

    // The prescale counter is at least one bit wide, even when PRESCALE is 1.
    localparam int PW = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PSC_LAST = PW'(PRESCALE - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] reload;
    logic [PW-1:0]    psc;

    // busy decodes the state flop directly; zero is a plain compare on cnt.
    assign busy = (state == RUN);
    assign zero = (cnt == '0);

    // Control FSM, count register, reload register and prescaler.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            reload  <= '0;
            psc     <= '0;
            expired <= 1'b0;
        end else begin
            expired <= 1'b0;
            if (stop && state == RUN) begin
                // Pause: keep the count, drop any partial prescale progress.
                state <= IDLE;
                psc   <= '0;
            end else if (load) begin
                cnt    <= load_val;
                reload <= load_val;
                psc    <= '0;
                if (state == RUN && load_val == '0) begin
                    // Loading zero while running ends the run without an expiry.
                    state <= IDLE;
                end else if (state == IDLE && start && !stop && load_val != '0) begin
                    state <= RUN;
                end
            end else if (state == IDLE && start && !stop) begin
                // A zero count has nothing to count down, so start is ignored.
                if (cnt != '0) begin
                    state <= RUN;
                    psc   <= '0;
                end
            end else if (state == RUN && tick) begin
                if (psc == PSC_LAST) begin
                    psc <= '0;
                    if (cnt == WIDTH'(1)) begin
                        expired <= 1'b1;
                        if (auto_reload && reload != '0) begin
                            cnt <= reload;
                        end else begin
                            cnt   <= '0;
                            state <= IDLE;
                        end
                    end else begin
                        cnt <= cnt - WIDTH'(1);
                    end
                end else begin
                    psc <= psc + PW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_countdown_timer.sv
// tb_countdown_timer: drives one stimulus stream into two timers (PRESCALE 1
// and 4). A tick-budget reference model predicts each cycle's outputs into a
// per-DUT expected queue; a monitor pops and compares after every edge.
module tb_countdown_timer;

    localparam int WIDTH = 8;
    localparam int EW    = WIDTH + 3;

    // ---------------- clock / reset block ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst = 1'b1;
    logic             load = 1'b0;
    logic [WIDTH-1:0] load_val = '0;
    logic             start = 1'b0;
    logic             stop = 1'b0;
    logic             tick = 1'b0;
    logic             auto_reload = 1'b0;

    logic [WIDTH-1:0] cnt1, cnt4;
    logic             busy1, zero1, expired1;
    logic             busy4, zero4, expired4;

    countdown_timer #(.WIDTH(WIDTH), .PRESCALE(1)) dut_p1 (
        .clk(clk), .rst(rst), .load(load), .load_val(load_val),
        .start(start), .stop(stop), .tick(tick), .auto_reload(auto_reload),
        .cnt(cnt1), .busy(busy1), .zero(zero1), .expired(expired1)
    );

    countdown_timer #(.WIDTH(WIDTH), .PRESCALE(4)) dut_p4 (
        .clk(clk), .rst(rst), .load(load), .load_val(load_val),
        .start(start), .stop(stop), .tick(tick), .auto_reload(auto_reload),
        .cnt(cnt4), .busy(busy4), .zero(zero4), .expired(expired4)
    );

    int checks = 0;
    int errors = 0;

    // ---------------- reference model ----------------
    // Index 0 models PRESCALE=1, index 1 models PRESCALE=4. The model keeps a
    // budget of ticks still needed before the next decrement.
    int ticks_per_dec [2] = '{1, 4};
    int m_cnt    [2] = '{0, 0};
    int m_reload [2] = '{0, 0};
    int m_left   [2] = '{0, 0};
    bit m_run    [2] = '{1'b0, 1'b0};
    bit m_exp    [2] = '{1'b0, 1'b0};

    logic [EW-1:0] exp_q1[$];
    logic [EW-1:0] exp_q4[$];

    task automatic model_step(input int d);
        m_exp[d] = 1'b0;
        if (rst) begin
            m_cnt[d] = 0; m_reload[d] = 0; m_left[d] = 0; m_run[d] = 1'b0;
        end else if (stop && m_run[d]) begin
            m_run[d] = 1'b0;
        end else if (load) begin
            m_cnt[d]    = int'(load_val);
            m_reload[d] = int'(load_val);
            m_left[d]   = ticks_per_dec[d];
            if (m_run[d] && load_val == 0) m_run[d] = 1'b0;
            else if (!m_run[d] && start && !stop && load_val != 0) m_run[d] = 1'b1;
        end else if (!m_run[d] && start && !stop) begin
            if (m_cnt[d] > 0) begin
                m_run[d]  = 1'b1;
                m_left[d] = ticks_per_dec[d];
            end
        end else if (m_run[d] && tick) begin
            m_left[d] = m_left[d] - 1;
            if (m_left[d] == 0) begin
                m_left[d] = ticks_per_dec[d];
                if (m_cnt[d] > 1) begin
                    m_cnt[d] = m_cnt[d] - 1;
                end else begin
                    m_exp[d] = 1'b1;
                    if (auto_reload && m_reload[d] > 0) begin
                        m_cnt[d] = m_reload[d];
                    end else begin
                        m_cnt[d] = 0;
                        m_run[d] = 1'b0;
                    end
                end
            end
        end
    endtask

    function automatic logic [EW-1:0] pack_exp(input int d);
        logic [WIDTH-1:0] c;
        c = WIDTH'(m_cnt[d]);
        return {c, m_run[d], (m_cnt[d] == 0), m_exp[d]};
    endfunction

    // ---------------- driver tasks ----------------
    // Inputs are set at the falling edge; cyc() records the prediction for
    // the coming rising edge and then advances to the next falling edge.
    task automatic cyc();
        model_step(0);
        model_step(1);
        exp_q1.push_back(pack_exp(0));
        exp_q4.push_back(pack_exp(1));
        @(negedge clk);
    endtask

    task automatic clr();
        rst = 1'b0; load = 1'b0; start = 1'b0; stop = 1'b0; tick = 1'b0;
    endtask

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // ---------------- scoreboard monitor ----------------
    logic [EW-1:0] got_v, exp_v;

    always @(posedge clk) begin
        #1;
        if (exp_q1.size() > 0) begin
            exp_v = exp_q1.pop_front();
            got_v = {cnt1, busy1, zero1, expired1};
            checks++;
            if (got_v !== exp_v) begin
                errors++;
                $display("FAIL sb_p1 t=%0t: got cnt=%0d busy=%b zero=%b exp=%b, expected cnt=%0d busy=%b zero=%b exp=%b",
                         $time, got_v[EW-1:3], got_v[2], got_v[1], got_v[0],
                         exp_v[EW-1:3], exp_v[2], exp_v[1], exp_v[0]);
            end
        end
        if (exp_q4.size() > 0) begin
            exp_v = exp_q4.pop_front();
            got_v = {cnt4, busy4, zero4, expired4};
            checks++;
            if (got_v !== exp_v) begin
                errors++;
                $display("FAIL sb_p4 t=%0t: got cnt=%0d busy=%b zero=%b exp=%b, expected cnt=%0d busy=%b zero=%b exp=%b",
                         $time, got_v[EW-1:3], got_v[2], got_v[1], got_v[0],
                         exp_v[EW-1:3], exp_v[2], exp_v[1], exp_v[0]);
            end
        end
    end

    // ---------------- stimulus ----------------
    int pulses1, pulses4;

    initial begin
        // Reset with random activity on every other input.
        for (int i = 0; i < 3; i++) begin
            rst = 1'b1;
            load = ($urandom_range(0, 1) == 1);
            load_val = WIDTH'($urandom_range(0, 255));
            start = ($urandom_range(0, 1) == 1);
            stop = ($urandom_range(0, 1) == 1);
            tick = ($urandom_range(0, 1) == 1);
            auto_reload = ($urandom_range(0, 1) == 1);
            cyc();
        end
        clr(); auto_reload = 1'b0;
        chk("rst_cnt", int'(cnt1), 0);
        chk("rst_busy", int'(busy1), 0);
        chk("rst_expired", int'(expired1), 0);
        chk("rst_zero", int'(zero1), 1);
        chk("rst_cnt_p4", int'(cnt4), 0);
        start = 1'b1; cyc(); clr();
        chk("start_no_load_idle", int'(busy1), 0);

        // One-shot countdown from 5.
        load = 1'b1; load_val = 8'd5; cyc(); clr();
        start = 1'b1; cyc(); clr();
        chk("busy_rise", int'(busy1), 1);
        tick = 1'b1;
        repeat (5) cyc();
        chk("oneshot_cnt", int'(cnt1), 0);
        chk("oneshot_busy_fall", int'(busy1), 0);
        chk("oneshot_expired", int'(expired1), 1);
        chk("oneshot_p4_cnt", int'(cnt4), 4);
        cyc();
        chk("oneshot_pulse_len", int'(expired1), 0);
        chk("oneshot_hold_zero", int'(cnt1), 0);
        repeat (15) cyc();
        chk("oneshot_p4_done_busy", int'(busy4), 0);
        chk("oneshot_p4_done_cnt", int'(cnt4), 0);

        // Auto-reload period 3 decrements.
        clr(); auto_reload = 1'b1;
        load = 1'b1; load_val = 8'd3; cyc(); clr();
        start = 1'b1; cyc(); clr();
        tick = 1'b1;
        pulses1 = 0; pulses4 = 0;
        repeat (36) begin
            cyc();
            pulses1 += int'(expired1);
            pulses4 += int'(expired4);
        end
        chk("auto_pulses_p1", pulses1, 12);
        chk("auto_pulses_p4", pulses4, 3);
        chk("auto_busy_p4", int'(busy4), 1);
        chk("auto_reload_cnt_p4", int'(cnt4), 3);
        clr(); auto_reload = 1'b0; stop = 1'b1; cyc(); clr();
        chk("auto_stopped", int'(busy1), 0);

        // Stop/resume from 10.
        load = 1'b1; load_val = 8'd10; cyc(); clr();
        start = 1'b1; cyc(); clr();
        tick = 1'b1; repeat (4) cyc();
        chk("run_to_6", int'(cnt1), 6);
        stop = 1'b1; start = 1'b1; cyc(); clr();
        chk("stop_start_idle", int'(busy1), 0);
        chk("stop_hold_cnt", int'(cnt1), 6);
        start = 1'b1; cyc(); clr();
        chk("resume_busy", int'(busy1), 1);
        tick = 1'b1; repeat (5) cyc();
        chk("resume_cnt_1", int'(cnt1), 1);
        chk("resume_no_early_exp", int'(expired1), 0);
        cyc();
        chk("resume_expired", int'(expired1), 1);
        chk("resume_idle", int'(busy1), 0);
        clr(); stop = 1'b1; cyc(); clr();

        // Collisions: load beats decrement; load 0 while running.
        load = 1'b1; load_val = 8'd2; cyc(); clr();
        start = 1'b1; cyc(); clr();
        tick = 1'b1; cyc();
        chk("coll_at_1", int'(cnt1), 1);
        load = 1'b1; load_val = 8'd9; cyc(); clr();
        chk("coll_load_wins", int'(cnt1), 9);
        chk("coll_no_expired", int'(expired1), 0);
        chk("coll_still_busy", int'(busy1), 1);
        load = 1'b1; load_val = 8'd0; cyc(); clr();
        chk("load0_idle", int'(busy1), 0);
        chk("load0_no_expired", int'(expired1), 0);
        chk("load0_idle_p4", int'(busy4), 0);

        // Mid-run reset from full scale.
        load = 1'b1; load_val = 8'd255; cyc(); clr();
        start = 1'b1; cyc(); clr();
        tick = 1'b1; repeat (20) cyc();
        chk("full_scale_20", int'(cnt1), 235);
        clr(); rst = 1'b1; tick = 1'b1; cyc(); clr();
        chk("midrst_cnt", int'(cnt1), 0);
        chk("midrst_busy", int'(busy1), 0);
        chk("midrst_zero", int'(zero1), 1);
        chk("midrst_cnt_p4", int'(cnt4), 0);
        start = 1'b1; cyc(); clr();
        chk("midrst_reload_cleared", int'(busy1), 0);

        // Randomized traffic, checked by the scoreboard.
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 63) == 0);
            load = ($urandom_range(0, 9) == 0);
            load_val = ($urandom_range(0, 1) == 1) ? WIDTH'($urandom_range(0, 6))
                                                   : WIDTH'($urandom_range(0, 255));
            start = ($urandom_range(0, 4) == 0);
            stop = ($urandom_range(0, 24) == 0);
            tick = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 49) == 0) auto_reload = ~auto_reload;
            cyc();
        end
        clr();
        repeat (2) cyc();

        chk("queue_drained_p1", exp_q1.size(), 0);
        chk("queue_drained_p4", exp_q4.size(), 0);

        // ---------------- final report ----------------
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
